// File: rtl/face_core_scheduler.sv
// face_core_scheduler: frame-level scheduler for a bank of face-detection cores.
// Takes one frame request, broadcasts the frame size and launches the cores one
// after another. It then tracks per-core completion and round-robin arbitrates
// the shared result-write port until all cores finish or the run phase times out.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start, size       : frame request and frame edge length (sampled together)
//   core_size         : latched frame size broadcast to all cores
//   core_mode         : 0 = cores run, 1 = cores held idle
//   core_start        : one-cycle launch pulse per core
//   core_done         : per-core completion level
//   wr_req, wr_last   : per-core write-port request and final-beat marker
//   wr_gnt            : one-hot (or zero) write-port grant
//   busy, all_done    : frame in progress / one-cycle frame-complete pulse
//   timeout, size_err : run phase exceeded limit / rejected undersized frame
//   done_mask         : cores that have reported done this frame
//   cycle_cnt         : active-phase cycle count, saturating
module face_core_scheduler #(
  parameter int          NUM_CORES      = 9,
  parameter int          LAUNCH_GAP     = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd4_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          size,
  output logic [31:0]          core_size,
  output logic                 core_mode,
  output logic [NUM_CORES-1:0] core_start,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] wr_req,
  input  logic [NUM_CORES-1:0] wr_last,
  output logic [NUM_CORES-1:0] wr_gnt,
  output logic                 busy,
  output logic                 all_done,
  output logic                 timeout,
  output logic                 size_err,
  output logic [NUM_CORES-1:0] done_mask,
  output logic [31:0]          cycle_cnt
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NUM_CORES-1:0] ONE = NUM_CORES'(1);

  typedef enum logic [2:0] {StIdle, StLaunch, StRun, StDrain, StFinish} state_e;

  state_e               state;
  logic [IDX_W-1:0]     launch_idx;  // index of the most recently launched core
  logic [31:0]          gap_cnt;     // cycles since the most recent launch pulse
  logic [NUM_CORES-1:0] launched;
  logic [IDX_W-1:0]     rr_ptr;      // first index searched on the next grant

  logic                 active;
  logic                 timeout_hit;
  logic [NUM_CORES-1:0] done_next;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     pick_next;
  int                   j;

  always_comb begin
    active      = (state == StLaunch) || (state == StRun) || (state == StDrain);
    timeout_hit = ((state == StRun) || (state == StDrain)) && (cycle_cnt == TIMEOUT_CYCLES);
    // Done reports from cores not yet launched are masked off.
    done_next   = done_mask | (core_done & launched);

    // Round-robin search starting at rr_ptr, wrapping at NUM_CORES.
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!pick_valid && wr_req[IDX_W'(j)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
    pick_next = (pick_idx == IDX_W'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      launch_idx <= '0;
      gap_cnt    <= '0;
      launched   <= '0;
      rr_ptr     <= '0;
      core_size  <= '0;
      core_mode  <= 1'b1;
      core_start <= '0;
      wr_gnt     <= '0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
      timeout    <= 1'b0;
      size_err   <= 1'b0;
      done_mask  <= '0;
      cycle_cnt  <= '0;
    end else begin
      core_start <= '0;
      all_done   <= 1'b0;

      if (active) begin
        if (cycle_cnt != 32'hFFFF_FFFF) cycle_cnt <= cycle_cnt + 32'd1;
        done_mask <= done_next;
        if (wr_gnt != '0) begin
          // Release on final beat, or when the owner abandons its request.
          if (((wr_req & wr_gnt) == '0) || ((wr_last & wr_gnt) != '0)) wr_gnt <= '0;
        end else if (pick_valid) begin
          wr_gnt <= ONE << pick_idx;
          rr_ptr <= pick_next;
        end
      end else begin
        wr_gnt <= '0;
      end

      unique case (state)
        StIdle: begin
          if (start) begin
            if (size >= 32'd8) begin
              state      <= StLaunch;
              core_size  <= size;
              core_mode  <= 1'b0;
              busy       <= 1'b1;
              core_start <= ONE;
              launched   <= ONE;
              launch_idx <= '0;
              gap_cnt    <= '0;
              done_mask  <= '0;
              cycle_cnt  <= '0;
              timeout    <= 1'b0;
              size_err   <= 1'b0;
            end else begin
              size_err <= 1'b1;
            end
          end
        end
        StLaunch: begin
          if ((launch_idx == IDX_W'(NUM_CORES - 1)) && (gap_cnt == '0)) begin
            state <= StRun;
          end else if (gap_cnt == 32'(LAUNCH_GAP - 1)) begin
            launch_idx <= launch_idx + 1'b1;
            gap_cnt    <= '0;
            core_start <= ONE << (launch_idx + 1'b1);
            launched   <= launched | (ONE << (launch_idx + 1'b1));
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        StRun, StDrain: begin
          if (timeout_hit) begin
            state     <= StFinish;
            timeout   <= 1'b1;
            wr_gnt    <= '0;
            core_mode <= 1'b1;
            all_done  <= 1'b1;
          end else if (state == StRun) begin
            // Use the updated mask so a final done moves to DRAIN immediately.
            if (&done_next) state <= StDrain;
          end else if ((wr_gnt == '0) && (wr_req == '0)) begin
            state     <= StFinish;
            core_mode <= 1'b1;
            all_done  <= 1'b1;
          end
        end
        StFinish: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_face_core_scheduler.sv
// Testbench for face_core_scheduler: scoreboard of expected launch pulses, grant
// changes and all_done pulses, each tagged with the cycle it must appear in.
module tb_face_core_scheduler;

  localparam int N   = 9;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   size;
  logic [31:0]   core_size;
  logic          core_mode;
  logic [N-1:0]  core_start;
  logic [N-1:0]  core_done;
  logic [N-1:0]  wr_req;
  logic [N-1:0]  wr_last;
  logic [N-1:0]  wr_gnt;
  logic          busy;
  logic          all_done;
  logic          timeout;
  logic          size_err;
  logic [N-1:0]  done_mask;
  logic [31:0]   cycle_cnt;

  always #5 clk = ~clk;

  face_core_scheduler #(
    .NUM_CORES     (N),
    .LAUNCH_GAP    (GAP),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .core_size (core_size),
    .core_mode (core_mode),
    .core_start(core_start),
    .core_done (core_done),
    .wr_req    (wr_req),
    .wr_last   (wr_last),
    .wr_gnt    (wr_gnt),
    .busy      (busy),
    .all_done  (all_done),
    .timeout   (timeout),
    .size_err  (size_err),
    .done_mask (done_mask),
    .cycle_cnt (cycle_cnt)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } ev_t;

  ev_t      launch_q[$];
  ev_t      gnt_q[$];
  int       done_q[$];
  int       cyc = 0;
  int       n_tests = 0;
  int       n_fail = 0;
  bit       mon_en = 1'b0;
  logic [N-1:0] prev_gnt;
  ev_t      mev;
  int       dcyc;
  int       s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    gnt_q.push_back(e);
  endtask

  // Output monitor: every launch pulse, grant change and all_done pulse must
  // match the head of its scoreboard queue, including the cycle number.
  always @(negedge clk) begin
    if (mon_en) begin
      if (core_start != '0) begin
        if (launch_q.size() == 0) check("launch_extra", 32'(core_start), 32'd0);
        else begin
          mev = launch_q.pop_front();
          check("launch_val", 32'(core_start), mev.val);
          check("launch_cyc", cyc, mev.cyc);
        end
      end
      if (wr_gnt != prev_gnt) begin
        if (gnt_q.size() == 0) check("gnt_extra", 32'(wr_gnt), 32'(prev_gnt));
        else begin
          mev = gnt_q.pop_front();
          check("gnt_val", 32'(wr_gnt), mev.val);
          check("gnt_cyc", cyc, mev.cyc);
        end
      end
      prev_gnt = wr_gnt;
      if (all_done) begin
        if (done_q.size() == 0) check("all_done_extra", 32'(all_done), 32'd0);
        else begin
          dcyc = done_q.pop_front();
          check("all_done_cyc", cyc, dcyc);
        end
      end
    end
  end

  task automatic start_frame(input logic [31:0] sz, output int st);
    tick();
    start = 1'b1;
    size  = sz;
    st    = cyc;
    for (int i = 0; i < N; i++) begin
      ev_t e;
      e.cyc = st + 1 + GAP * i;
      e.val = 32'd1 << i;
      launch_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_launch();
    for (int k = 0; k < 60 && launch_q.size() != 0; k++) tick();
    check("launch_drained", launch_q.size(), 0);
  endtask

  // Requests a and b together; a granted first and released by wr_last, then b.
  task automatic rr_last(input int a, input int b);
    int r;
    tick();
    r = cyc;
    wr_req = '0;
    wr_req[a] = 1'b1;
    wr_req[b] = 1'b1;
    push_gnt(r + 1, 32'd1 << a);
    push_gnt(r + 4, 32'd0);
    push_gnt(r + 5, 32'd1 << b);
    push_gnt(r + 7, 32'd0);
    tick();
    tick();
    tick();
    wr_last[a] = 1'b1;
    tick();
    wr_req[a]  = 1'b0;
    wr_last[a] = 1'b0;
    tick();
    tick();
    wr_last[b] = 1'b1;
    tick();
    wr_req  = '0;
    wr_last = '0;
  endtask

  // Requests a and b together; a is granted, then abandons its request.
  task automatic rr_drop(input int a, input int b);
    int r;
    tick();
    r = cyc;
    wr_req = '0;
    wr_req[a] = 1'b1;
    wr_req[b] = 1'b1;
    push_gnt(r + 1, 32'd1 << a);
    push_gnt(r + 2, 32'd0);
    push_gnt(r + 3, 32'd1 << b);
    push_gnt(r + 4, 32'd0);
    tick();
    wr_req[a] = 1'b0;
    tick();
    tick();
    wr_last[b] = 1'b1;
    tick();
    wr_req  = '0;
    wr_last = '0;
  endtask

  task automatic finish_all(input int st);
    int t;
    tick();
    t = cyc;
    core_done = '1;
    done_q.push_back(t + 2);
    for (int k = 0; k < 20 && done_q.size() != 0; k++) tick();
    check("done_wait", done_q.size(), 0);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_all_done", all_done, 0);
    check("idle_core_mode", core_mode, 1);
    check("idle_done_mask", done_mask, 32'h1FF);
    check("idle_cycle_cnt", cycle_cnt, t + 1 - st);
    core_done = '0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    size      = '0;
    core_done = '0;
    wr_req    = '0;
    wr_last   = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_core_mode", core_mode, 1);
    check("rst_core_start", core_start, 0);
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_done_mask", done_mask, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_core_size", core_size, 0);
    check("rst_flags", {all_done, timeout, size_err}, 0);
    prev_gnt = wr_gnt;
    mon_en   = 1'b1;

    // Undersized frame is rejected.
    tick();
    start = 1'b1;
    size  = 32'd5;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("err_size_err", size_err, 1);
    check("err_busy", busy, 0);
    repeat (3) tick();
    check("err_still_idle", busy, 0);

    // Normal frame with arbitration traffic.
    start_frame(32'd96, s);
    @(negedge clk);
    check("a_core_size", core_size, 96);
    check("a_core_mode", core_mode, 0);
    check("a_busy", busy, 1);
    check("a_size_err_clr", size_err, 0);
    wait_launch();
    tick();
    start = 1'b1;
    size  = 32'd200;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("a_start_ignored", core_size, 96);
    rr_last(2, 5);
    rr_drop(7, 1);
    finish_all(s);

    // Timeout: core 4 never finishes.
    core_done = 9'h1EF;
    start_frame(32'd64, s);
    repeat (4) tick();
    @(negedge clk);
    check("b_mask_unlaunched", done_mask, 32'h3);
    done_q.push_back(s + 102);
    for (int k = 0; k < 200 && done_q.size() != 0; k++) tick();
    check("b_done_wait", done_q.size(), 0);
    @(negedge clk);
    check("b_timeout", timeout, 1);
    check("b_done_mask", done_mask, 32'h1EF);
    check("b_cycle_cnt", cycle_cnt, 101);
    check("b_busy", busy, 0);
    core_done = '0;

    // Reset in the middle of a grant.
    start_frame(32'd8, s);
    @(negedge clk);
    check("c_core_size", core_size, 8);
    wait_launch();
    tick();
    s = cyc;
    wr_req = 9'h008;
    push_gnt(s + 1, 32'h8);
    push_gnt(s + 3, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    wr_req = '0;
    @(negedge clk);
    check("c_wr_gnt", wr_gnt, 0);
    check("c_busy", busy, 0);
    check("c_done_mask", done_mask, 0);
    check("c_core_mode", core_mode, 1);
    check("c_cycle_cnt", cycle_cnt, 0);
    check("c_core_size", core_size, 0);

    // Frame after reset: round-robin pointer restarts at 0.
    start_frame(32'd16, s);
    @(negedge clk);
    check("d_core_size", core_size, 16);
    check("d_busy", busy, 1);
    wait_launch();
    rr_drop(0, 8);
    finish_all(s);

    repeat (3) tick();
    check("left_launch", launch_q.size(), 0);
    check("left_gnt", gnt_q.size(), 0);
    check("left_done", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
